// File: rtl/song_sequencer.sv
// Song sequencer: walks the note ROM one {end, note, duration} entry at a time and holds each note for its duration in beats.
// Latency: play to first note 3 cycles; 3-cycle gap (FETCH, LOAD, PLAY) between notes; stop acts on the next edge.
// Backpressure: none; beats arriving in FETCH/LOAD or while paused are dropped, and play is ignored while busy.
module song_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic                            stop,
  input  logic                            pause,
  input  logic                            beat,
  output logic [ADDR_WIDTH-1:0]           rom_addr,
  input  logic [NOTE_WIDTH+DUR_WIDTH:0]   rom_data,
  output logic                            beat_en,
  output logic                            beat_clr,
  output logic [NOTE_WIDTH-1:0]           note_out,
  output logic                            note_strobe,
  output logic                            busy,
  output logic                            song_done
);

  localparam int ROM_W = 1 + NOTE_WIDTH + DUR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_WIDTH-1:0]   note_q, note_d;
  logic [DUR_WIDTH-1:0]    remaining_q, remaining_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;
  logic                    clr_q, clr_d;
  logic                    busy_q, busy_d;

  // ROM entry fields; a zero duration is promoted to one beat so remaining never underflows.
  logic                    rom_end;
  logic [NOTE_WIDTH-1:0]   rom_note;
  logic [DUR_WIDTH-1:0]    rom_dur;
  logic [DUR_WIDTH-1:0]    rom_dur_min1;

  assign rom_end      = rom_data[ROM_W-1];
  assign rom_note     = rom_data[DUR_WIDTH +: NOTE_WIDTH];
  assign rom_dur      = rom_data[DUR_WIDTH-1:0];
  assign rom_dur_min1 = (rom_dur == '0) ? DUR_WIDTH'(1) : rom_dur;

  // Next-state and registered-output logic; stop overrides every other event.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    note_d      = note_q;
    remaining_d = remaining_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    clr_d       = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      note_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (play) begin
            state_d    = S_FETCH;
            rom_addr_d = '0;
            note_d     = '0;
            clr_d      = 1'b1;
          end
        end
        S_FETCH: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (rom_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            note_d  = '0;
          end else begin
            state_d     = S_PLAY;
            note_d      = rom_note;
            remaining_d = rom_dur_min1;
            strobe_d    = 1'b1;
          end
        end
        S_PLAY: begin
          if (beat && !pause) begin
            if (remaining_q > DUR_WIDTH'(1)) begin
              remaining_d = remaining_q - DUR_WIDTH'(1);
            end else begin
              note_d = '0;
              // The song never wraps: the last address finishes it.
              if (&rom_addr_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d    = S_FETCH;
                rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          rom_addr_d = '0;
          note_d     = '0;
        end
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_PLAY);
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      note_q      <= '0;
      remaining_q <= '0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      note_q      <= note_d;
      remaining_q <= remaining_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
    end
  end

  // The beat counter enable is the only combinational output.
  always_comb begin
    beat_en = (state_q == S_PLAY) && !pause;
  end

  assign rom_addr    = rom_addr_q;
  assign note_out    = note_q;
  assign note_strobe = strobe_q;
  assign song_done   = done_q;
  assign beat_clr    = clr_q;
  assign busy        = busy_q;

endmodule
